// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the program-counter sequencer
// Purpose: FSM state encoding and the instruction-memory address width used by
//          the sequencer, its next-PC helper and the harness interface.
// Ports:   none (package).
package pc_sequencer_pkg;

  // Instruction-memory address width; the PC is exactly this wide by default.
  localparam int kPC_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - harness/ALU-side signal bundle for the program-counter sequencer
// Purpose: groups the control inputs (start, stall, branch result, ALU strobes)
//          and the sequencer outputs (PC, status, retired count).
// Ports:   none; modport master = harness/ALU side, modport slave = sequencer.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);

  logic              START;
  logic              STALL;
  logic              BRANCH;
  logic [7:0]        bOFFSET;
  logic              bSIGN;
  logic              ALU_RESET;
  logic              ALU_HALT;
  logic [PC_W-1:0]   PC;
  logic              RUNNING;
  logic              DONE;
  logic              IMEM_EN;
  logic [CNT_W-1:0]  INSN_CNT;

  modport master (
    output START, STALL, BRANCH, bOFFSET, bSIGN, ALU_RESET, ALU_HALT,
    input  PC, RUNNING, DONE, IMEM_EN, INSN_CNT
  );

  modport slave (
    input  START, STALL, BRANCH, bOFFSET, bSIGN, ALU_RESET, ALU_HALT,
    output PC, RUNNING, DONE, IMEM_EN, INSN_CNT
  );

endinterface

// File: rtl/pc_sequencer_pc_next.sv
// rtl/pc_sequencer_pc_next.sv - combinational next-PC selection for a retiring instruction
// Purpose: picks soft-reset target, branch target or fall-through address.
//          Halt is handled by the caller, which simply does not load the result.
// Ports:   pc_i (current PC), branch_i, b_offset_i (unsigned magnitude),
//          b_sign_i (1 = backward), alu_reset_i; pc_nxt_o (next PC, mod 2^PC_W).
module pc_next
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W       = kPC_W,
  parameter int START_ADDR = 0
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_i,
  input  logic [7:0]      b_offset_i,
  input  logic            b_sign_i,
  input  logic            alu_reset_i,
  output logic [PC_W-1:0] pc_nxt_o
);

  logic [PC_W-1:0] off_ext;

  always_comb begin
    // Size cast zero-extends for wide PCs and truncates for PC_W < 8.
    off_ext = PC_W'(b_offset_i);
    if (alu_reset_i) begin
      pc_nxt_o = PC_W'(START_ADDR);
    end else if (branch_i) begin
      // Wrap-around in both directions falls out of fixed-width arithmetic.
      pc_nxt_o = b_sign_i ? (pc_i - off_ext) : (pc_i + off_ext);
    end else begin
      pc_nxt_o = pc_i + PC_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter controller with start/done handshake and retire counter
// Purpose: IDLE/RUN/DONE sequencing of the single-cycle core's PC, ALU-driven
//          branches, soft reset and halt, plus a saturating retired-instruction count.
// Ports:   CLK, RST_N (async, active low); bus (slave modport): START, STALL,
//          BRANCH, bOFFSET, bSIGN, ALU_RESET, ALU_HALT in; PC, RUNNING, DONE,
//          IMEM_EN, INSN_CNT out.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W       = kPC_W,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic           CLK,
  input  logic           RST_N,
  pc_sequencer_if.slave  bus
);

  pc_state_e        state_q,   state_d;
  logic [PC_W-1:0]  pc_q,      pc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             running_q, running_d;
  logic             done_q,    done_d;
  logic [PC_W-1:0]  pc_nxt;

  pc_next #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_pc_next (
    .pc_i        (pc_q),
    .branch_i    (bus.BRANCH),
    .b_offset_i  (bus.bOFFSET),
    .b_sign_i    (bus.bSIGN),
    .alu_reset_i (bus.ALU_RESET),
    .pc_nxt_o    (pc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    running_d = running_q;
    done_d    = done_q;
    case (state_q)
      IDLE, DONE: begin
        // STALL has no effect outside RUN; only START matters here.
        if (bus.START) begin
          state_d   = RUN;
          pc_d      = PC_W'(START_ADDR);
          cnt_d     = '0;
          running_d = 1'b1;
          done_d    = 1'b0;
        end
      end
      RUN: begin
        if (!bus.STALL) begin
          // Every unstalled RUN cycle retires, including the halt itself.
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (bus.ALU_HALT) begin
            // PC stays on the halt instruction for post-mortem inspection.
            state_d   = DONE;
            running_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            pc_d = pc_nxt;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pc_d      = PC_W'(START_ADDR);
        cnt_d     = '0;
        running_d = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      pc_q      <= PC_W'(START_ADDR);
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.RUNNING  = running_q;
  assign bus.DONE     = done_q;
  assign bus.INSN_CNT = cnt_q;
  assign bus.IMEM_EN  = running_q & ~bus.STALL;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for the program-counter sequencer
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
    logic        imem;
  } exp_t;

  exp_t exp_q[$];
  int   step_no = 0;

  pc_sequencer_if #(.PC_W(10), .CNT_W(16)) bus ();

  pc_sequencer #(
    .PC_W       (10),
    .START_ADDR (0),
    .CNT_W      (16)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d actual %0d required %0d", name, idx, act, req);
    end
  endtask

  // Drives one cycle of inputs and queues the hand-computed state after the edge.
  task automatic step(input logic start, input logic stall, input logic br,
                      input logic [7:0] off, input logic sgn, input logic arst,
                      input logic halt, input logic [9:0] e_pc, input logic e_run,
                      input logic e_done, input logic [15:0] e_cnt);
    exp_t e;
    @(negedge clk);
    bus.START     = start;
    bus.STALL     = stall;
    bus.BRANCH    = br;
    bus.bOFFSET   = off;
    bus.bSIGN     = sgn;
    bus.ALU_RESET = arst;
    bus.ALU_HALT  = halt;
    step_no++;
    e.idx  = step_no;
    e.pc   = e_pc;
    e.run  = e_run;
    e.done = e_done;
    e.cnt  = e_cnt;
    e.imem = e_run & ~stall;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: outputs are valid every cycle; compare whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",       e.idx, 32'(bus.PC),       32'(e.pc));
        check("running",  e.idx, 32'(bus.RUNNING),  32'(e.run));
        check("done",     e.idx, 32'(bus.DONE),     32'(e.done));
        check("insn_cnt", e.idx, 32'(bus.INSN_CNT), 32'(e.cnt));
        check("imem_en",  e.idx, 32'(bus.IMEM_EN),  32'(e.imem));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.START = 0; bus.STALL = 0; bus.BRANCH = 0; bus.bOFFSET = 0;
    bus.bSIGN = 0; bus.ALU_RESET = 0; bus.ALU_HALT = 0;
    rst_n = 0;
    #12;
    check("rst_pc",      0, 32'(bus.PC),       0);
    check("rst_running", 0, 32'(bus.RUNNING),  0);
    check("rst_done",    0, 32'(bus.DONE),     0);
    check("rst_cnt",     0, 32'(bus.INSN_CNT), 0);
    check("rst_imem",    0, 32'(bus.IMEM_EN),  0);
    @(negedge clk);
    rst_n = 1;

    //   start stall br off  sgn rst halt   pc   run done cnt
    step(0, 0, 0, 8'd0,  0, 0, 0, 10'd0,    0, 0, 16'd0);   // idle holds
    step(1, 0, 0, 8'd0,  0, 0, 0, 10'd0,    1, 0, 16'd0);   // start
    step(0, 0, 0, 8'd0,  0, 0, 0, 10'd1,    1, 0, 16'd1);
    step(0, 0, 0, 8'd0,  0, 0, 0, 10'd2,    1, 0, 16'd2);
    step(0, 0, 0, 8'd0,  0, 0, 0, 10'd3,    1, 0, 16'd3);
    step(0, 0, 0, 8'd0,  0, 0, 0, 10'd4,    1, 0, 16'd4);
    step(0, 0, 0, 8'd0,  0, 0, 0, 10'd5,    1, 0, 16'd5);
    step(1, 0, 0, 8'd0,  0, 0, 0, 10'd6,    1, 0, 16'd6);   // start ignored in RUN
    step(0, 0, 1, 8'd14, 0, 0, 0, 10'd20,   1, 0, 16'd7);   // forward to 20
    step(0, 0, 1, 8'd6,  1, 0, 0, 10'd14,   1, 0, 16'd8);   // 20-6
    step(0, 0, 1, 8'd1,  0, 0, 0, 10'd15,   1, 0, 16'd9);   // not taken
    step(0, 0, 1, 8'd0,  0, 0, 0, 10'd15,   1, 0, 16'd10);  // self-loop
    step(0, 0, 1, 8'd19, 1, 0, 0, 10'd1020, 1, 0, 16'd11);  // 15-19 wraps
    step(0, 0, 1, 8'd8,  0, 0, 0, 10'd4,    1, 0, 16'd12);  // 1020+8 wraps
    step(0, 0, 1, 8'd1,  1, 0, 0, 10'd3,    1, 0, 16'd13);
    step(0, 0, 1, 8'd5,  1, 0, 0, 10'd1022, 1, 0, 16'd14);  // 3-5 wraps
    step(0, 0, 1, 8'd32, 0, 0, 0, 10'd30,   1, 0, 16'd15);  // 1022+32 wraps
    step(0, 0, 0, 8'd0,  0, 1, 0, 10'd0,    1, 0, 16'd16);  // soft reset
    step(0, 1, 1, 8'd7,  0, 0, 0, 10'd0,    1, 0, 16'd16);  // stalled
    step(0, 1, 0, 8'd7,  0, 0, 1, 10'd0,    1, 0, 16'd16);
    step(0, 1, 1, 8'd3,  1, 1, 1, 10'd0,    1, 0, 16'd16);
    step(0, 0, 1, 8'd9,  0, 0, 0, 10'd9,    1, 0, 16'd17);
    step(0, 0, 1, 8'd3,  0, 1, 1, 10'd9,    0, 1, 16'd18);  // halt wins
    step(0, 1, 1, 8'd3,  0, 0, 0, 10'd9,    0, 1, 16'd18);  // DONE holds
    step(1, 1, 0, 8'd0,  0, 0, 0, 10'd0,    1, 0, 16'd0);   // restart, stall ignored
    step(0, 0, 0, 8'd0,  0, 0, 0, 10'd1,    1, 0, 16'd1);
    step(0, 0, 0, 8'd0,  0, 0, 0, 10'd2,    1, 0, 16'd2);

    begin : drain
      int n = 0;
      while (exp_q.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain pending %0d required 0", exp_q.size());
      end
    end

    // Asynchronous reset mid-RUN, observed between clock edges.
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    check("arst_pc",      0, 32'(bus.PC),       0);
    check("arst_running", 0, 32'(bus.RUNNING),  0);
    check("arst_done",    0, 32'(bus.DONE),     0);
    check("arst_cnt",     0, 32'(bus.INSN_CNT), 0);
    check("arst_imem",    0, 32'(bus.IMEM_EN),  0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 1, 8'd4,  0, 0, 0, 10'd0,    0, 0, 16'd0);   // back in IDLE
    @(posedge clk);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter controller that sequences the ALU-based single-cycle core. It consumes the ALU's branch result (bOFFSET, bSIGN) and its reset/halt strobes, and produces the instruction-memory address each cycle. It also owns the start/done handshake with the test harness and keeps a retired-instruction counter.

Parameters:
PC_W, 10, program counter width; all PC arithmetic is modulo 2^PC_W.
START_ADDR, 0, PC value on reset, start and soft reset.
CNT_W, 16, width of the retired-instruction counter.

Ports:
CLK  in  1  core clock; all state updates on rising edge.
RST_N  in  1  asynchronous, active-low reset.
START  in  1  start request; sampled in IDLE and DONE only.
STALL  in  1  freeze; while high no state, PC or counter changes occur.
BRANCH  in  1  current instruction is kBRC or kBRR (from decoder).
bOFFSET  in  8  unsigned branch magnitude from ALU (1 when not taken).
bSIGN  in  1  branch direction from ALU: 1 = backward (subtract), 0 = forward.
ALU_RESET  in  1  ALU kRST strobe.
ALU_HALT  in  1  ALU halt strobe (kRST with T=1).
PC  out  PC_W  current instruction address (registered).
RUNNING  out  1  high in RUN state (registered).
DONE  out  1  high in DONE state; held until next accepted START (registered).
IMEM_EN  out  1  RUNNING & ~STALL (combinational).
INSN_CNT  out  CNT_W  instructions retired since last accepted START.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, PC=START_ADDR, RUNNING=0, DONE=0, INSN_CNT=0; IMEM_EN=0 follows from RUNNING=0.
- States: IDLE, RUN, DONE.
- IDLE: START=1 -> RUN next cycle with PC=START_ADDR and INSN_CNT=0. START=0 -> stay.
- RUN with STALL=1: hold everything. ALU and branch inputs are ignored.
- RUN with STALL=0 retires one instruction. INSN_CNT+1, saturating at 2^CNT_W-1. Next PC is chosen by priority:
  1. ALU_HALT=1 (ALU_RESET value ignored) -> state=DONE; PC holds (points at halt instruction).
  2. ALU_RESET=1 -> PC=START_ADDR; stay RUN.
  3. BRANCH=1 -> PC = PC + zext(bOFFSET) if bSIGN=0, PC - zext(bOFFSET) if bSIGN=1.
  4. Otherwise -> PC = PC + 1.
- Branch arithmetic: bOFFSET zero-extended (or truncated if PC_W<8) to PC_W, result mod 2^PC_W.
  - Forward past the top wraps to low addresses; backward below 0 wraps to the top.
  - bOFFSET=0 with BRANCH=1 holds PC, a legal self-loop; the counter still increments.
- START while in RUN: ignored.
- DONE: RUNNING=0, DONE=1, PC and INSN_CNT held.
  - START=1 -> RUN, PC=START_ADDR, INSN_CNT=0, DONE drops the same edge.
  - STALL is ignored in IDLE and DONE.
- Latency: PC update is visible one cycle after the retiring edge; DONE rises one cycle after the halt cycle.
- RST_N asserted mid-RUN: immediate return to reset values; no completion reported.
- Simultaneous ALU_HALT and BRANCH: halt wins, no branch taken.

Decomposition:
- The definitions package gains typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_e, plus constant kPC_W = 10 shared with the instruction-memory address width.
- One combinational sub-module, pc_next, computes the next PC from (PC, BRANCH, bOFFSET, bSIGN, ALU_RESET). The FSM, counter and output registers stay in pc_sequencer.

Test Plan:
- Reset then START pulse, 5 non-branch cycles -> PC 0,1,2,3,4,5; INSN_CNT=5; RUNNING=1, DONE=0.
- At PC=20, BRANCH=1, bOFFSET=6, bSIGN=1 -> PC=14. Then BRANCH=1, bOFFSET=1, bSIGN=0 (not taken) -> PC=15.
- PC_W=10 wrap: PC=1020, bOFFSET=8, bSIGN=0 -> PC=4. PC=3, bOFFSET=5, bSIGN=1 -> PC=1022.
- At PC=30, ALU_RESET=1, ALU_HALT=0 -> PC=0, still RUN. Later ALU_RESET=1, ALU_HALT=1, BRANCH=1 at PC=9 -> DONE=1 next cycle, PC stays 9.
- STALL held 3 cycles mid-RUN with BRANCH/ALU_HALT toggling -> PC, INSN_CNT and state unchanged; IMEM_EN=0 throughout.
- DONE then START -> PC=0, INSN_CNT=0, RUNNING=1. RST_N pulled low mid-RUN asynchronously -> all outputs at reset values before next CLK edge.
